// File: rtl/pix_proc_rr_pkg.sv
// Shared types and constants for the round-robin pixel-processing stage.
package pix_proc_pkg;

   localparam int COLOR_SIZE = 8;
   localparam int PIXEL_SIZE = 24;

   typedef enum logic [1:0] {
      MODE_PASS = 2'd0,
      MODE_ADD  = 2'd1,
      MODE_SUB  = 2'd2,
      MODE_THR  = 2'd3
   } mode_t;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_BURST = 1'b1
   } state_t;

   // Index width for n items, never narrower than one bit.
   function automatic int idx_bits(input int n);
      if (n <= 2) return 1;
      return $clog2(n);
   endfunction

endpackage

// File: rtl/pix_proc_rr_if.sv
// Bundle of the per-channel slave streams and the single master output port.
interface pix_proc_rr_if import pix_proc_pkg::*; #(
   parameter int NUM_CH     = 4,
   parameter int DATA_WIDTH = 32
) ();

   localparam int CH_W = idx_bits(NUM_CH);

   logic [NUM_CH-1:0][1:0]            slv_mode;
   logic [NUM_CH-1:0][COLOR_SIZE-1:0] slv_proc_val;
   logic [NUM_CH-1:0]                 slv_data_valid;
   logic [NUM_CH-1:0][DATA_WIDTH-1:0] slv_data;
   logic [NUM_CH-1:0]                 slv_rdy;

   logic                              mstr_ready;
   logic                              mstr_data_valid;
   logic [DATA_WIDTH-1:0]             mstr_data;
   logic [CH_W-1:0]                   mstr_src;
   logic                              mstr_cmplt;

   // Processing unit: sinks the channel bursts, sources the output stream.
   modport slave (
      input  slv_mode, slv_proc_val, slv_data_valid, slv_data, mstr_ready,
      output slv_rdy, mstr_data_valid, mstr_data, mstr_src, mstr_cmplt
   );

   // Environment: drives the channel bursts, consumes the output stream.
   modport master (
      output slv_mode, slv_proc_val, slv_data_valid, slv_data, mstr_ready,
      input  slv_rdy, mstr_data_valid, mstr_data, mstr_src, mstr_cmplt
   );

endinterface

// File: rtl/pix_proc_rr_color_alu.sv
// Single-color operator: pass, saturating add/sub, or threshold against proc_val.
module pix_color_alu import pix_proc_pkg::*; (
   input  logic [COLOR_SIZE-1:0] i_color,
   input  mode_t                 i_mode,
   input  logic [COLOR_SIZE-1:0] i_proc_val,
   output logic [COLOR_SIZE-1:0] o_result
);

   logic [COLOR_SIZE:0] w_sum;

   // Select the per-mode result; add carries into a spare bit to detect overflow.
   always_comb begin
      w_sum    = {1'b0, i_color} + {1'b0, i_proc_val};
      o_result = i_color;
      case (i_mode)
         MODE_PASS: o_result = i_color;
         MODE_ADD:  o_result = w_sum[COLOR_SIZE] ? '1 : w_sum[COLOR_SIZE-1:0];
         MODE_SUB:  o_result = (i_color < i_proc_val) ? '0 : (i_color - i_proc_val);
         MODE_THR:  o_result = (i_color >= i_proc_val) ? '1 : '0;
         default:   o_result = i_color;
      endcase
   end

endmodule

// File: rtl/pix_proc_rr.sv
// Round-robin burst arbiter feeding a one-stage RGB processor and a
// backpressured output register tagged with the source channel.
module pix_proc_rr import pix_proc_pkg::*; #(
   parameter int NUM_CH     = 4,
   parameter int DATA_WIDTH = 32,
   parameter int BURST_LEN  = 64
) (
   input  logic          clk,
   input  logic          rst_n,
   pix_proc_rr_if.slave  bus
);

   localparam int CH_W  = idx_bits(NUM_CH);
   localparam int CNT_W = idx_bits(BURST_LEN);

   state_t                r_state;
   logic [CH_W-1:0]       r_grant;
   logic [CH_W-1:0]       r_last_grant;
   logic [CNT_W-1:0]      r_beat_cnt;
   mode_t                 r_mode;
   logic [COLOR_SIZE-1:0] r_proc_val;

   logic                  r_out_valid;
   logic [DATA_WIDTH-1:0] r_out_data;
   logic [CH_W-1:0]       r_out_src;
   logic                  r_out_cmplt;

   logic                  w_req_any;
   logic                  w_found;
   logic [CH_W-1:0]       w_next;
   logic [CH_W-1:0]       w_idx;
   logic                  w_out_free;
   logic                  w_accept;
   logic                  w_last;
   logic [PIXEL_SIZE-1:0] w_pix;
   logic [PIXEL_SIZE-1:0] w_proc_pix;

   assign w_req_any  = |bus.slv_data_valid;
   assign w_out_free = !r_out_valid || bus.mstr_ready;
   assign w_accept   = (r_state == ST_BURST) && bus.slv_data_valid[r_grant] && w_out_free;
   assign w_last     = (r_beat_cnt == CNT_W'(BURST_LEN - 1));
   assign w_pix      = bus.slv_data[r_grant][PIXEL_SIZE-1:0];

   // Pick the first requester after the previous winner, wrapping around.
   always_comb begin
      w_next  = r_last_grant;
      w_found = 1'b0;
      w_idx   = '0;
      for (int unsigned i = 1; i <= NUM_CH; i++) begin
         w_idx = CH_W'((32'(r_last_grant) + i) % NUM_CH);
         if (!w_found && bus.slv_data_valid[w_idx]) begin
            w_next  = w_idx;
            w_found = 1'b1;
         end
      end
   end

   // Only the granted channel sees ready, and only when the output slot can take a beat.
   always_comb begin
      bus.slv_rdy = '0;
      if (r_state == ST_BURST) begin
         bus.slv_rdy[r_grant] = w_out_free;
      end
   end

   pix_color_alu u_alu_r (
      .i_color    (w_pix[23:16]),
      .i_mode     (r_mode),
      .i_proc_val (r_proc_val),
      .o_result   (w_proc_pix[23:16])
   );

   pix_color_alu u_alu_g (
      .i_color    (w_pix[15:8]),
      .i_mode     (r_mode),
      .i_proc_val (r_proc_val),
      .o_result   (w_proc_pix[15:8])
   );

   pix_color_alu u_alu_b (
      .i_color    (w_pix[7:0]),
      .i_mode     (r_mode),
      .i_proc_val (r_proc_val),
      .o_result   (w_proc_pix[7:0])
   );

   // Arbitration FSM, beat counter, per-burst mode latch and output register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_IDLE;
         r_grant      <= '0;
         r_last_grant <= CH_W'(NUM_CH - 1);
         r_beat_cnt   <= '0;
         r_mode       <= MODE_PASS;
         r_proc_val   <= '0;
         r_out_valid  <= 1'b0;
         r_out_data   <= '0;
         r_out_src    <= '0;
         r_out_cmplt  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_req_any) begin
                  r_grant    <= w_next;
                  r_beat_cnt <= '0;
                  r_mode     <= mode_t'(bus.slv_mode[w_next]);
                  r_proc_val <= bus.slv_proc_val[w_next];
                  r_state    <= ST_BURST;
               end
            end
            ST_BURST: begin
               if (w_accept) begin
                  if (w_last) begin
                     r_last_grant <= r_grant;
                     r_state      <= ST_IDLE;
                  end else begin
                     r_beat_cnt <= r_beat_cnt + 1'b1;
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase

         if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_data  <= DATA_WIDTH'(w_proc_pix);
            r_out_src   <= r_grant;
            r_out_cmplt <= w_last;
         end else if (bus.mstr_ready) begin
            r_out_valid <= 1'b0;
            r_out_cmplt <= 1'b0;
         end
      end
   end

   assign bus.mstr_data_valid = r_out_valid;
   assign bus.mstr_data       = r_out_data;
   assign bus.mstr_src        = r_out_src;
   assign bus.mstr_cmplt      = r_out_cmplt;

endmodule

// File: tb/tb_pix_proc_rr.sv
// Directed bench for pix_proc_rr: vector table of per-mode bursts plus
// round-robin, backpressure, mid-burst mode change and mid-burst reset sequences.
module tb_pix_proc_rr;
   import pix_proc_pkg::*;

   localparam int NCH = 4;
   localparam int DW  = 32;
   localparam int BL  = 4;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   pix_proc_rr_if #(.NUM_CH(NCH), .DATA_WIDTH(DW)) bus ();

   pix_proc_rr #(.NUM_CH(NCH), .DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      logic [1:0]  mode;
      logic [7:0]  val;
      logic [31:0] pix;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs [6];

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   logic [31:0] pq [NCH][32];
   int          head [NCH];
   int          tail [NCH];
   int          acc_cnt [NCH];
   logic        rdy_in;

   logic [31:0] got_d [64];
   logic [7:0]  got_s [64];
   logic        got_c [64];
   int          got_t [64];
   int          got_n;
   logic [31:0] exp_d [64];
   logic [7:0]  exp_s [64];
   logic        exp_c [64];
   int          exp_n;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One cycle: drive at the falling edge, then note accepts and transfers due at the next rising edge.
   task automatic step();
      @(negedge clk);
      cyc++;
      bus.mstr_ready = rdy_in;
      for (int c = 0; c < NCH; c++) begin
         bus.slv_data_valid[c] = (head[c] < tail[c]);
         bus.slv_data[c]       = (head[c] < tail[c]) ? pq[c][head[c]] : '0;
      end
      #1;
      for (int c = 0; c < NCH; c++) begin
         if (bus.slv_data_valid[c] && bus.slv_rdy[c]) begin
            head[c]++;
            acc_cnt[c]++;
         end
      end
      if (bus.mstr_data_valid && bus.mstr_ready && got_n < 64) begin
         got_d[got_n] = bus.mstr_data;
         got_s[got_n] = 8'(bus.mstr_src);
         got_c[got_n] = bus.mstr_cmplt;
         got_t[got_n] = cyc;
         got_n++;
      end
   endtask

   task automatic push(input int c, input logic [31:0] pix);
      if (tail[c] < 32) begin
         pq[c][tail[c]] = pix;
         tail[c]++;
      end
   endtask

   task automatic expect_beat(input logic [31:0] d, input logic [7:0] s, input logic cm);
      if (exp_n < 64) begin
         exp_d[exp_n] = d;
         exp_s[exp_n] = s;
         exp_c[exp_n] = cm;
         exp_n++;
      end
   endtask

   task automatic drain(input string name, input int budget);
      int  n;
      logic done;
      n    = 0;
      done = 1'b0;
      while (!done && n < budget) begin
         step();
         n++;
         done = !bus.mstr_data_valid;
         for (int c = 0; c < NCH; c++) if (head[c] < tail[c]) done = 1'b0;
      end
      check({name, "_drain"}, 64'(done), 64'd1);
   endtask

   task automatic compare_sb(input string name);
      check({name, "_count"}, 64'(got_n), 64'(exp_n));
      for (int i = 0; i < got_n && i < exp_n; i++) begin
         check($sformatf("%s_beat%0d", name, i),
               64'({got_d[i], got_s[i], got_c[i]}),
               64'({exp_d[i], exp_s[i], exp_c[i]}));
      end
      got_n = 0;
      exp_n = 0;
   endtask

   task automatic clear_queues();
      for (int c = 0; c < NCH; c++) begin
         head[c]    = 0;
         tail[c]    = 0;
         acc_cnt[c] = 0;
      end
      bus.slv_data_valid = '0;
      bus.slv_data       = '0;
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      rst_n = 1'b0;
      clear_queues();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      int n;
      logic [31:0] bp_exp [4];

      vecs[0] = '{2'd1, 8'h20, 32'h0010F0E0, 32'h0030FFFF};
      vecs[1] = '{2'd2, 8'h40, 32'h003080C0, 32'h00004080};
      vecs[2] = '{2'd3, 8'h80, 32'h007F80FF, 32'h0000FFFF};
      vecs[3] = '{2'd0, 8'h00, 32'hAB123456, 32'h00123456};
      vecs[4] = '{2'd1, 8'h01, 32'h00FEFF00, 32'h00FFFF01};
      vecs[5] = '{2'd2, 8'h01, 32'h00000102, 32'h00000001};

      rst_n              = 1'b0;
      rdy_in             = 1'b1;
      bus.mstr_ready     = 1'b1;
      bus.slv_mode       = '0;
      bus.slv_proc_val   = '0;
      got_n              = 0;
      exp_n              = 0;
      clear_queues();

      #1;
      check("reset_master", 64'({bus.mstr_data_valid, bus.mstr_data, bus.mstr_src, bus.mstr_cmplt}), 64'd0);
      check("reset_rdy", 64'(bus.slv_rdy), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Per-mode bursts on channel 0; the first also checks grant timing and latency.
      for (int v = 0; v < 6; v++) begin
         bus.slv_mode[0]     = vecs[v].mode;
         bus.slv_proc_val[0] = vecs[v].val;
         for (int b = 0; b < BL; b++) begin
            push(0, vecs[v].pix);
            expect_beat(vecs[v].exp, 8'd0, b == BL - 1);
         end
         if (v == 0) begin
            step();
            check("idle_rdy", 64'(bus.slv_rdy), 64'd0);
            step();
            check("grant_rdy", 64'(bus.slv_rdy), 64'b0001);
            step();
            check("latency", 64'({bus.mstr_data_valid, bus.mstr_data}), 64'({1'b1, vecs[0].exp}));
         end
         drain($sformatf("vec%0d", v), 40);
         compare_sb($sformatf("vec%0d", v));
      end

      // All channels request at once after reset: 0,1,2,3,0 with one bubble per handover.
      pulse_reset();
      bus.slv_mode     = '0;
      bus.slv_proc_val = '0;
      for (int k = 0; k < 2 * BL; k++) push(0, 32'h00000000 | (32'(k / BL) << 8) | 32'(k % BL));
      for (int c = 1; c < NCH; c++)
         for (int b = 0; b < BL; b++) push(c, (32'(c) << 16) | 32'(b));
      for (int b = 0; b < BL; b++) expect_beat(32'(b), 8'd0, b == BL - 1);
      for (int c = 1; c < NCH; c++)
         for (int b = 0; b < BL; b++) expect_beat((32'(c) << 16) | 32'(b), 8'(c), b == BL - 1);
      for (int b = 0; b < BL; b++) expect_beat(32'h100 | 32'(b), 8'd0, b == BL - 1);
      drain("rr", 80);
      check("rr_bubble", 64'(got_t[4] - got_t[3]), 64'd2);
      check("rr_span", 64'(got_t[19] - got_t[0]), 64'd23);
      compare_sb("rr");

      // Output stall of five cycles in the middle of a channel 2 burst.
      bus.slv_mode[2]     = 2'd1;
      bus.slv_proc_val[2] = 8'h01;
      acc_cnt[2]          = 0;
      for (int b = 0; b < BL; b++) begin
         push(2, 32'h00102030 + 32'h00010101 * 32'(b));
         bp_exp[b] = 32'h00112131 + 32'h00010101 * 32'(b);
         expect_beat(bp_exp[b], 8'd2, b == BL - 1);
      end
      n = 0;
      while (acc_cnt[2] < 2 && n < 30) begin
         step();
         n++;
      end
      check("bp_reach", 64'(acc_cnt[2]), 64'd2);
      rdy_in = 1'b0;
      for (int s = 0; s < 5; s++) begin
         step();
         check($sformatf("bp_hold%0d", s),
               64'({bus.mstr_data_valid, bus.mstr_cmplt, bus.mstr_src, bus.mstr_data}),
               64'({1'b1, 1'b0, 2'd2, bp_exp[1]}));
         check($sformatf("bp_rdy%0d", s), 64'(bus.slv_rdy), 64'd0);
      end
      rdy_in = 1'b1;
      drain("bp", 40);
      compare_sb("bp");

      // Mode/operand change after two beats affects only the next burst.
      bus.slv_mode[3]     = 2'd1;
      bus.slv_proc_val[3] = 8'h10;
      acc_cnt[3]          = 0;
      push(3, 32'h00102030); expect_beat(32'h00203040, 8'd3, 1'b0);
      push(3, 32'h00F5F0EF); expect_beat(32'h00FFFFFF, 8'd3, 1'b0);
      push(3, 32'h00000000); expect_beat(32'h00101010, 8'd3, 1'b0);
      push(3, 32'h00EFFF10); expect_beat(32'h00FFFF20, 8'd3, 1'b1);
      n = 0;
      while (acc_cnt[3] < 2 && n < 30) begin
         step();
         n++;
      end
      check("mc_reach", 64'(acc_cnt[3]), 64'd2);
      bus.slv_mode[3]     = 2'd3;
      bus.slv_proc_val[3] = 8'h25;
      push(3, 32'h00252424); expect_beat(32'h00FF0000, 8'd3, 1'b0);
      push(3, 32'h0024FF00); expect_beat(32'h0000FF00, 8'd3, 1'b0);
      push(3, 32'h00262626); expect_beat(32'h00FFFFFF, 8'd3, 1'b0);
      push(3, 32'h00000025); expect_beat(32'h000000FF, 8'd3, 1'b1);
      drain("mc", 60);
      compare_sb("mc");

      // Reset mid-burst on channel 1, then channel 0 must win and complete a full burst.
      bus.slv_mode[1] = 2'd0;
      acc_cnt[1]      = 0;
      for (int b = 0; b < BL; b++) push(1, 32'h00AAAA00 + 32'(b));
      n = 0;
      while (acc_cnt[1] < 3 && n < 30) begin
         step();
         n++;
      end
      check("rst_reach", 64'(acc_cnt[1]), 64'd3);
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_async_master", 64'({bus.mstr_data_valid, bus.mstr_data, bus.mstr_src, bus.mstr_cmplt}), 64'd0);
      check("rst_async_rdy", 64'(bus.slv_rdy), 64'd0);
      clear_queues();
      got_n = 0;
      exp_n = 0;
      @(negedge clk);
      rst_n = 1'b1;
      bus.slv_mode     = '0;
      bus.slv_proc_val = '0;
      for (int b = 0; b < BL; b++) begin
         push(2, 32'h00220000 + 32'(b));
         push(0, 32'h00000C00 + 32'(b));
      end
      for (int b = 0; b < BL; b++) expect_beat(32'h00000C00 + 32'(b), 8'd0, b == BL - 1);
      for (int b = 0; b < BL; b++) expect_beat(32'h00220000 + 32'(b), 8'd2, b == BL - 1);
      drain("post_rst", 60);
      compare_sb("post_rst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached (checks=%0d failures=%0d)", checks, failures);
      $fatal(1, "watchdog");
   end

endmodule
